hazard_scoreboard: RTL

//  Sequences the decode stage: per-register scoreboard for long-latency ops (loads, cache-miss

---
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register busy scoreboard for long-latency writes,
// plus load-use, WAW and capacity checks driving fetch/decode stall and flush controls.
module hazard_scoreboard #(
  parameter  int REG_BITS    = 5,
  parameter  int MAX_PENDING = 4,
  localparam int NREGS       = 2**REG_BITS,
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_D_in,
  input  logic [REG_BITS-1:0] rs1_D_in,
  input  logic [REG_BITS-1:0] rs2_D_in,
  input  logic [REG_BITS-1:0] rd_D_in,
  input  logic                use_rs1_D_in,
  input  logic                use_rs2_D_in,
  input  logic                reg_write_D_in,
  input  logic                long_D_in,
  input  logic                flush_in,
  input  logic [REG_BITS-1:0] rd_WB_in,
  input  logic                long_wb_in,
  output logic                stall_F_out,
  output logic                stall_D_out,
  output logic                flush_D_out,
  output logic                flush_E_out,
  output logic [NREGS-1:0]    busy_out,
  output logic [CNT_W-1:0]    pending_cnt_out,
  output logic                err_out
);

  logic [NREGS-1:0]    busy_q, busy_d;
  logic [CNT_W-1:0]    pending_cnt_q, pending_cnt_d;
  logic                e_valid_q, e_valid_d;
  logic [REG_BITS-1:0] e_rd_q, e_rd_d;
  logic                e_long_q, e_long_d;
  logic                err_q, err_d;

  logic [NREGS-1:0]    pend_vec;
  logic [NREGS-1:0]    set_vec;
  logic [NREGS-1:0]    clr_vec;
  logic                e_set;
  logic                wb_hit;
  logic                raw, waw, cap, hz;
  logic                stall;
  logic                issue;

  // The long op currently in EX is committed past the flush point; it becomes busy next edge.
  assign e_set = e_valid_q & e_long_q;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign pend_vec[gi] = 1'b0;
      assign set_vec[gi]  = 1'b0;
      assign clr_vec[gi]  = 1'b0;
      assign busy_d[gi]   = 1'b0;
    end else begin : g_nz
      // pend covers the one-cycle gap before the EX producer shows up in busy
      assign pend_vec[gi] = busy_q[gi] | (e_set & (e_rd_q == REG_BITS'(gi)));
      assign set_vec[gi]  = e_set & (e_rd_q == REG_BITS'(gi));
      assign clr_vec[gi]  = long_wb_in & (rd_WB_in == REG_BITS'(gi)) & busy_q[gi];
      assign busy_d[gi]   = set_vec[gi] | (busy_q[gi] & ~clr_vec[gi]);
    end
  end

  assign wb_hit = |clr_vec;

  always_comb begin
    raw   = (use_rs1_D_in & pend_vec[rs1_D_in]) | (use_rs2_D_in & pend_vec[rs2_D_in]);
    waw   = reg_write_D_in & pend_vec[rd_D_in];
    cap   = long_D_in & ((int'(pending_cnt_q) + int'(e_set)) >= MAX_PENDING);
    hz    = valid_D_in & (raw | waw | cap);
    stall = hz & ~flush_in;
    issue = valid_D_in & ~stall & ~flush_in;
  end

  always_comb begin
    e_valid_d     = issue;
    e_rd_d        = rd_D_in;
    e_long_d      = long_D_in & reg_write_D_in & (rd_D_in != '0);
    pending_cnt_d = pending_cnt_q;
    // Set and clear on the same edge cancel: one producer retires, another takes its place.
    if (e_set && !wb_hit) begin
      if (pending_cnt_q != CNT_W'(MAX_PENDING)) pending_cnt_d = pending_cnt_q + CNT_W'(1);
    end else if (!e_set && wb_hit) begin
      if (pending_cnt_q != '0) pending_cnt_d = pending_cnt_q - CNT_W'(1);
    end
    err_d = err_q | (long_wb_in & ~wb_hit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q        <= '0;
      pending_cnt_q <= '0;
      e_valid_q     <= 1'b0;
      e_rd_q        <= '0;
      e_long_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
      e_valid_q     <= e_valid_d;
      e_rd_q        <= e_rd_d;
      e_long_q      <= e_long_d;
      err_q         <= err_d;
    end
  end

  // Outputs are gated by reset so they read zero the instant reset asserts.
  assign stall_F_out     = stall & reset;
  assign stall_D_out     = stall & reset;
  assign flush_D_out     = flush_in & reset;
  assign flush_E_out     = (flush_in | stall) & reset;
  assign busy_out        = busy_q;
  assign pending_cnt_out = pending_cnt_q;
  assign err_out         = err_q;

endmodule
